// File: rtl/spi_eep_slave.sv
// -----------------------------------------------------------------------------
// spi_eep_slave
//
// SPI slave standing in for the calibration EEPROM. Receives 16-bit frames
// (MSB first: [15:14] op, [13:8] addr, [7:0] data) on SS_n/SCLK/MOSI,
// executes writes into a 64-byte array and reads into a response register,
// and returns that response on MISO during the following frame.
//
//   op 2'b01 : write   mem[addr] <= data
//   op 2'b00 : read    rsp <= {8'h00, mem[addr]}
//   op 2'b1x : no-op
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   SS_n, SCLK, MOSI  SPI inputs, asynchronous to clk
//   MISO              serial response, 0 whenever the slave is not shifting
//   wr_pulse          one-cycle strobe per array write
//   wr_addr, wr_data  address/data of the most recent write (held)
//   frm_err           one-cycle strobe when a frame ends with count != 16
//
// Parameters:
//   SYNC_STAGES       synchronizer depth for the SPI inputs (2 or 3)
//   INIT_VAL          reset value of every array byte
//
// Build option:
//   SPI_EEP_WRPROT_EN  when defined, addresses 6'h00-6'h0F are write-protected
//                      while wp_lock is set. Write frame 16'h7F5A clears the
//                      lock, 16'h7FA5 sets it; neither is stored.
// -----------------------------------------------------------------------------
module spi_eep_slave #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  INIT_VAL    = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SS_n,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    output logic       wr_pulse,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frm_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, EXEC} state_t;

    // SS_n/SCLK carry one extra history flop behind the synchronizer so edges
    // come from the last two stages.
    localparam int CHAIN = SYNC_STAGES + 1;

    logic [CHAIN-1:0]       ss_sync, sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;

    logic ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;

    state_t      state_q, state_d;
    logic [15:0] rx_sr, tx_sr, rsp;
    logic [4:0]  bit_cnt;
    logic        held_fall;
    logic [7:0]  mem [64];

    logic [1:0]  op;
    logic [5:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic        mem_we;

`ifdef SPI_EEP_WRPROT_EN
    logic wp_lock;
    logic key_unlock, key_lock;
`endif

    // The SS_n chain resets to "selected": if SS_n is already low when reset
    // releases, no fall is seen and a half-finished frame is never picked up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
        end else begin
            ss_sync   <= {ss_sync[CHAIN-2:0], SS_n};
            sclk_sync <= {sclk_sync[CHAIN-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
        end
    end

    assign ss_fall   =  ss_sync[CHAIN-1]   & ~ss_sync[CHAIN-2];
    assign ss_rise   = ~ss_sync[CHAIN-1]   &  ss_sync[CHAIN-2];
    assign sclk_rise = ~sclk_sync[CHAIN-1] &  sclk_sync[CHAIN-2];
    assign sclk_fall =  sclk_sync[CHAIN-1] & ~sclk_sync[CHAIN-2];
    assign mosi_s    =  mosi_sync[SYNC_STAGES-1];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_fall || held_fall) state_d = SHIFT;
            SHIFT:   if (ss_rise) state_d = (bit_cnt == 5'd16) ? EXEC : IDLE;
            EXEC:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- decode
    assign op       = rx_sr[15:14];
    assign cmd_addr = rx_sr[13:8];
    assign cmd_data = rx_sr[7:0];

    always_comb begin
        mem_we = (state_q == EXEC) && (op == 2'b01);
`ifdef SPI_EEP_WRPROT_EN
        key_unlock = (rx_sr[13:0] == 14'h3F5A);
        key_lock   = (rx_sr[13:0] == 14'h3FA5);
        if (key_unlock || key_lock || (wp_lock && cmd_addr[5:4] == 2'b00))
            mem_we = 1'b0;
`endif
    end

    // ---------------------------------------------------------------- datapath
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sr     <= '0;
            tx_sr     <= '0;
            rsp       <= '0;
            bit_cnt   <= '0;
            held_fall <= 1'b0;
            wr_pulse  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frm_err   <= 1'b0;
`ifdef SPI_EEP_WRPROT_EN
            wp_lock   <= 1'b1;
`endif
        end else begin
            wr_pulse  <= 1'b0;
            frm_err   <= 1'b0;
            // A select arriving during EXEC is remembered and taken from IDLE.
            held_fall <= (state_q == EXEC) && ss_fall;
            case (state_q)
                IDLE: begin
                    if (state_d == SHIFT) begin
                        bit_cnt <= '0;
                        tx_sr   <= rsp;
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        if (bit_cnt != 5'd16) frm_err <= 1'b1;
                    end else begin
                        if (sclk_rise) begin
                            rx_sr <= {rx_sr[14:0], mosi_s};
                            if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
                        end
                        if (sclk_fall) tx_sr <= {tx_sr[14:0], 1'b0};
                    end
                end
                EXEC: begin
                    if (mem_we) begin
                        wr_pulse <= 1'b1;
                        wr_addr  <= cmd_addr;
                        wr_data  <= cmd_data;
                    end
                    if (op == 2'b00) rsp <= {8'h00, mem[cmd_addr]};
`ifdef SPI_EEP_WRPROT_EN
                    if (op == 2'b01 && key_unlock) wp_lock <= 1'b0;
                    if (op == 2'b01 && key_lock)   wp_lock <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    // NOTE: the array is reset because its power-up contents are defined
    // (INIT_VAL); this costs a reset on every byte rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= INIT_VAL;
        end else if (mem_we) begin
            mem[cmd_addr] <= cmd_data;
        end
    end

    assign MISO = (state_q == SHIFT) & tx_sr[15];

endmodule

// File: tb/tb_spi_eep_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_eep_slave
//
// Drives SPI frames into spi_eep_slave and checks MISO frames, write strobes
// and frame-error strobes against a frame-level reference model. Expected
// responses are queued when each frame is issued; independent monitors pop
// and compare whenever the DUT presents a result.
// -----------------------------------------------------------------------------
module tb_spi_eep_slave;

    localparam logic [7:0] INIT = 8'h5C;
    localparam int         HALF = 8;     // SCLK half period in clk cycles

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ss_n  = 1'b1;
    logic       sclk  = 1'b0;
    logic       mosi  = 1'b0;
    logic       miso;
    logic       wr_pulse;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       frm_err;

    spi_eep_slave #(.SYNC_STAGES(3), .INIT_VAL(INIT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (ss_n),
        .SCLK     (sclk),
        .MOSI     (mosi),
        .MISO     (miso),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .frm_err  (frm_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ reference model
    typedef struct {
        logic [15:0] rsp;
        int          nbits;
        bit          skip;
    } miso_exp_t;

    miso_exp_t   miso_q[$];
    logic [13:0] wr_q[$];
    int          err_q[$];

    logic [7:0]  m_mem [64];
    logic [15:0] m_rsp;
    logic        m_lock;
    logic [5:0]  m_last_a;
    logic [7:0]  m_last_d;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = INIT;
        m_rsp    = 16'h0000;
        m_lock   = 1'b1;
        m_last_a = 6'h00;
        m_last_d = 8'h00;
    endtask

    task automatic model_frame(input logic [15:0] word, input int nbits);
        logic [1:0] op;
        logic [5:0] a;
        logic [7:0] d;
        bit         store;
        miso_exp_t  e;
        op = word[15:14];
        a  = word[13:8];
        d  = word[7:0];
        e.rsp = m_rsp; e.nbits = nbits; e.skip = 1'b0;
        miso_q.push_back(e);
        if (nbits != 16) begin
            err_q.push_back(1);
        end else if (op == 2'b01) begin
            store = 1'b1;
`ifdef SPI_EEP_WRPROT_EN
            if (word[13:0] == 14'h3F5A) begin m_lock = 1'b0; store = 1'b0; end
            else if (word[13:0] == 14'h3FA5) begin m_lock = 1'b1; store = 1'b0; end
            else if (m_lock && a < 6'd16) store = 1'b0;
`endif
            if (store) begin
                m_mem[a] = d;
                m_last_a = a;
                m_last_d = d;
                wr_q.push_back({a, d});
            end
        end else if (op == 2'b00) begin
            m_rsp = {8'h00, m_mem[a]};
        end
    endtask

    // ------------------------------------------------------------ SPI master
    task automatic drive_bits(input logic [15:0] word, input int nbits);
        @(negedge clk) ss_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 16) ? word[15-i] : 1'b0;
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_frame(input logic [15:0] word, input int nbits);
        model_frame(word, nbits);
        drive_bits(word, nbits);
        ss_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    // Frame cut short by reset: nothing of it may take effect.
    task automatic spi_abort(input logic [15:0] word, input int nbits);
        miso_exp_t e;
        e.rsp = 16'h0; e.nbits = 0; e.skip = 1'b1;
        miso_q.push_back(e);
        drive_bits(word, nbits);
        rst_n = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        check("abort_miso_in_reset", miso, 1'b0);
        rst_n = 1'b1;
        repeat (HALF) @(negedge clk);
        check("abort_miso_after_reset", miso, 1'b0);
        ss_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        check("abort_miso_idle", miso, 1'b0);
    endtask

    // ------------------------------------------------------------ monitors
    initial begin
        logic [31:0] cap, expv;
        int          nb;
        miso_exp_t   e;
        forever begin
            @(negedge ss_n);
            cap = '0;
            nb  = 0;
            while (1) begin
                @(posedge sclk or posedge ss_n);
                if (ss_n) break;
                cap = {cap[30:0], miso};
                nb++;
            end
            if (miso_q.size() == 0) begin
                check("miso_frame_unexpected", 1, 0);
            end else begin
                e = miso_q.pop_front();
                if (!e.skip && nb > 0) begin
                    expv = '0;
                    for (int i = 0; i < nb; i++)
                        expv = {expv[30:0], (i < 16) ? e.rsp[15-i] : 1'b0};
                    check("miso_frame", cap, expv);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [13:0] w;
        if (rst_n && wr_pulse) begin
            if (wr_q.size() == 0) check("wr_pulse_unexpected", 1, 0);
            else begin
                w = wr_q.pop_front();
                check("wr_addr_data", {18'h0, wr_addr, wr_data}, {18'h0, w});
            end
        end
        if (rst_n && frm_err) begin
            if (err_q.size() == 0) check("frm_err_unexpected", 1, 0);
            else void'(err_q.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        logic [15:0] w;
        int          nb;

        model_reset();
        repeat (4) @(negedge clk);
        check("reset_miso",     miso,     1'b0);
        check("reset_wr_pulse", wr_pulse, 1'b0);
        check("reset_wr_addr",  wr_addr,  6'h00);
        check("reset_wr_data",  wr_data,  8'h00);
        check("reset_frm_err",  frm_err,  1'b0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Read of untouched byte returns INIT_VAL in the next frame.
        spi_frame(16'h0A00, 16);
        spi_frame(16'h0000, 16);

        // Write, read back, dummy frame carries the data.
        spi_frame(16'h4537, 16);
        spi_frame(16'h0500, 16);
        spi_frame(16'h0000, 16);
        spi_frame(16'h0000, 16);  // response is held across frames
        check("wr_hold", {wr_addr, wr_data}, {m_last_a, m_last_d});

        // Short frame: error strobe, nothing executed.
        spi_frame(16'h45EE, 12);
        spi_frame(16'h0500, 16);
        spi_frame(16'h0000, 16);

        // Reset in the middle of a write.
        spi_abort(16'h4CFF, 9);
        check("abort_wr_addr", wr_addr, 6'h00);
        spi_frame(16'h0C00, 16);
        spi_frame(16'h0000, 16);

        // Write-protect sequence (plain writes in the default build).
        spi_frame(16'h4311, 16);
        spi_frame(16'h7F5A, 16);
        spi_frame(16'h4311, 16);
        spi_frame(16'h0300, 16);
        spi_frame(16'h3F00, 16);
        spi_frame(16'h7FA5, 16);
        spi_frame(16'h4322, 16);
        spi_frame(16'h0300, 16);
        spi_frame(16'h0000, 16);

        // SCLK activity with SS_n high is ignored.
        for (int i = 0; i < 20; i++) begin
            repeat (HALF) @(negedge clk);
            sclk = ~sclk;
            check("idle_sclk_miso", miso, 1'b0);
        end
        sclk = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        spi_frame(16'h0000, 16);

        // Random frames, mostly reads/writes, some malformed lengths.
        for (int k = 0; k < 40; k++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 3) != 0) w[15] = 1'b0;
            nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 20)) : 16;
            spi_frame(w, nb);
        end
        spi_frame(16'h0000, 16);

        repeat (50) @(negedge clk);
        check("wr_q_drained",   wr_q.size(),   0);
        check("err_q_drained",  err_q.size(),  0);
        check("miso_q_drained", miso_q.size(), 0);
        check("final_wr_hold", {wr_addr, wr_data}, {m_last_a, m_last_d});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
